// File: rtl/enc_pack_pkg.sv
// Shared constants and entry layout for the encrypted-byte word packer.
package enc_pack_pkg;

  localparam int BYTE_W             = 8;
  localparam int COUNT_W            = 4;
  localparam int DEF_BYTES_PER_WORD = 4;
  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int DEF_WORD_W         = BYTE_W * DEF_BYTES_PER_WORD;

  // Entry layout at the default geometry; the packer stores the same field order at any width.
  typedef struct packed {
    logic [DEF_WORD_W-1:0] word;
    logic [COUNT_W-1:0]    count;
    logic [BYTE_W-1:0]     chk;
  } entry_t;

endpackage

// File: rtl/enc_pack_fifo.sv
// Show-ahead FIFO with registered full/empty flags; push and pop may coincide when not full.
module enc_pack_fifo
  import enc_pack_pkg::*;
#(
  parameter int WIDTH = DEF_WORD_W + COUNT_W + BYTE_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
    full_d  = (cnt_d == (AW+1)'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage carries data only; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;

endmodule

// File: rtl/enc_word_packer.sv
// Packs encrypted bytes MSB-lane-first into words queued in a show-ahead FIFO.
// Optional per-word XOR checksum enabled by defining ENC_PACK_CHKSUM_EN.
module enc_word_packer
  import enc_pack_pkg::*;
#(
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [7:0]                         in_byte,
  input  logic                               in_flush,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [8*BYTES_PER_WORD-1:0]        out_word,
  output logic [3:0]                         out_count,
  output logic [7:0]                         out_chk
);

  localparam int WORD_W   = BYTE_W * BYTES_PER_WORD;
  localparam int IDX_W    = $clog2(BYTES_PER_WORD);
`ifdef ENC_PACK_CHKSUM_EN
  localparam int ENTRY_W  = WORD_W + COUNT_W + BYTE_W;
`else
  localparam int ENTRY_W  = WORD_W + COUNT_W;
`endif

  // Lane 0 is most significant; writing lane 0 starts a fresh word so stale lanes read as zero.
  function automatic logic [WORD_W-1:0] insert_byte(input logic [WORD_W-1:0] acc,
                                                    input logic [IDX_W-1:0]  idx,
                                                    input logic [BYTE_W-1:0] b);
    logic [WORD_W-1:0] w;
    w = (idx == '0) ? '0 : acc;
    for (int l = 0; l < BYTES_PER_WORD; l++) begin
      if (idx == IDX_W'(l)) w[WORD_W-1-BYTE_W*l -: BYTE_W] = b;
    end
    return w;
  endfunction

  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0]  acc_q, acc_d;
  logic               accept;
  logic               push;
  logic [WORD_W-1:0]  push_word;
  logic [COUNT_W-1:0] push_count;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head_data;
  logic               fifo_full, fifo_empty;
  logic               pop;
`ifdef ENC_PACK_CHKSUM_EN
  logic [BYTE_W-1:0]  chk_q, chk_d;
  logic [BYTE_W-1:0]  push_chk;
`endif

  assign in_ready = !fifo_full && !reset;
  assign accept   = in_valid && in_ready;

  always_comb begin
    idx_d      = idx_q;
    acc_d      = acc_q;
    push       = 1'b0;
    push_word  = acc_q;
    push_count = COUNT_W'(idx_q);
`ifdef ENC_PACK_CHKSUM_EN
    chk_d      = chk_q;
    push_chk   = chk_q;
`endif
    if (accept) begin
      if (in_flush) begin
        // Flush beats carry no byte; an empty accumulator has nothing to close.
        if (idx_q != '0) begin
          push  = 1'b1;
          idx_d = '0;
        end
      end else begin
        acc_d      = insert_byte(acc_q, idx_q, in_byte);
        push_word  = acc_d;
        push_count = COUNT_W'(idx_q) + COUNT_W'(1);
`ifdef ENC_PACK_CHKSUM_EN
        chk_d      = (idx_q == '0) ? in_byte : (chk_q ^ in_byte);
        push_chk   = chk_d;
`endif
        if (idx_q == IDX_W'(BYTES_PER_WORD - 1)) begin
          push  = 1'b1;
          idx_d = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) idx_q <= '0;
    else       idx_q <= idx_d;
  end

  always_ff @(posedge clock) begin
    acc_q <= acc_d;
`ifdef ENC_PACK_CHKSUM_EN
    chk_q <= chk_d;
`endif
  end

`ifdef ENC_PACK_CHKSUM_EN
  assign push_data = {push_word, push_count, push_chk};
`else
  assign push_data = {push_word, push_count};
`endif

  enc_pack_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Outputs are forced to zero whenever no valid head is presented, including during reset.
  assign out_valid = !fifo_empty && !reset;
  assign pop       = out_valid && out_ready;
  assign out_word  = out_valid ? head_data[ENTRY_W-1 -: WORD_W] : '0;
  assign out_count = out_valid ? head_data[ENTRY_W-WORD_W-1 -: COUNT_W] : '0;
`ifdef ENC_PACK_CHKSUM_EN
  assign out_chk   = out_valid ? head_data[BYTE_W-1:0] : '0;
`else
  assign out_chk   = 8'h00;
`endif

endmodule

// File: doc/enc_word_packer.md
# enc_word_packer

Downstream stage of the 8-bit encryption datapath: consumes the stream of encrypted bytes produced by the encrypt stage and packs them into fixed-width words for the bus/storage side. Bytes arrive on a valid/ready handshake, are accumulated MSB-lane-first, and are committed into a small show-ahead output FIFO together with a byte count. An explicit flush closes a partial word. The block decouples encrypt-stage throughput from consumer backpressure.

## Interface
- BYTES_PER_WORD, 4, bytes per packed word; legal 2..8; WORD_W = 8*BYTES_PER_WORD
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2
- clock  in  1  single clock, all state on posedge
- reset  in  1  synchronous, active-high
- in_valid  in  1  in_byte / in_flush qualified
- in_ready  out  1  block accepts this cycle
- in_byte  in  8  encrypted byte
- in_flush  in  1  close current partial word
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_word  out  WORD_W  packed word, first byte in bits [WORD_W-1:WORD_W-8]
- out_count  out  4  valid bytes in out_word, 1..BYTES_PER_WORD
- out_chk  out  8  XOR checksum of valid bytes (see Configuration)

## Operation
- Clock and reset: one clock; reset is synchronous and active-high.
- Accept: transfer when in_valid && in_ready. in_flush is meaningful only on a transfer cycle; in_byte always consumed on a transfer (upstream sends a flush-only beat by holding in_flush with in_valid; in that case in_byte is ignored only if in_flush && byte_idx==0 is not the intent — rule: in_flush beats carry no byte).
- Accumulator: byte_idx counter 0..BYTES_PER_WORD-1, states EMPTY (idx 0) and PARTIAL (idx > 0). Byte written to lane idx (lane 0 = most significant); idx increments.
- Commit: on the transfer that fills lane BYTES_PER_WORD-1, or a flush beat in PARTIAL, {word, count, chk} pushed into FIFO; idx returns to 0; unused lanes zero.
- Flush in EMPTY: no-op, nothing pushed.
- in_ready = !fifo_full && !reset. Registered full flag only; no combinational path out_ready -> in_ready.
- FIFO: show-ahead; out_valid = !empty; pop on out_valid && out_ready. Push and pop in the same cycle allowed when not full; occupancy unchanged.
- Full: in_ready low even mid-word; accumulator holds. Pop while full frees a slot, in_ready high next cycle.
- Reset mid-operation: partial word discarded, FIFO emptied.

## Timing
- Reset values: in_ready 0 during reset, 1 first cycle after; out_valid 0; out_word 0; out_count 0; out_chk 0.
- Latency: committing transfer at edge N -> out_valid high after edge N (visible cycle N+1) if FIFO was empty.
- Throughput: one byte per cycle sustained while out_ready high.
- out_word/out_count/out_chk stable while out_valid && !out_ready.

## Configuration
- ENC_PACK_CHKSUM_EN defined: per-word XOR of accepted bytes accumulated alongside data, stored in FIFO, driven on out_chk.
- Undefined: checksum logic and FIFO storage removed; out_chk tied 8'h00; port list unchanged.

## Structure
- Package enc_pack_pkg: BYTE_W = 8, default BYTES_PER_WORD/FIFO_DEPTH, COUNT_W = 4, entry struct typedef {word, count, chk}.
- One sub-module: enc_pack_fifo (parameterised width/depth, show-ahead, full/empty flags, simultaneous push/pop).

## Test plan
- Bytes 8E,13,A5,F0 back-to-back, out_ready=1 -> out_word 32'h8E13A5F0, out_count 4, out_chk C8, out_valid one cycle after last accept.
- Bytes 11,22 then flush beat -> out_word 32'h11220000, out_count 2, out_chk 33; following flush with idx 0 -> no word.
- out_ready=0, stream 16 bytes -> 4 words queued, in_ready low after 4th commit; 17th byte held; raise out_ready -> words drain in order, in_ready returns one cycle after first pop.
- Bytes AA,BB then reset for one cycle, then 01,02,03,04 -> only 32'h01020304 emitted, count 4; all outputs 0 during reset.
- Simultaneous pop and commit with FIFO at 3/4 -> occupancy stays 3, no loss, order preserved.
- ENC_PACK_CHKSUM_EN undefined: first scenario -> same word/count, out_chk 00.
